pingpong_buf: RTL and testbench

PINGPONG_BUF -- requirements
Module: pingpong_buf

---
 rtl/pingpong_pkg.sv | 15 +
 rtl/pingpong_buf_bank.sv | 42 ++++
 rtl/pingpong_buf.sv | 106 ++++++++++
 tb/tb_pingpong_buf.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/pingpong_pkg.sv
// Shared constants for the ping-pong buffer: default geometry and the
// encoding of the per-bank status bit.
package pingpong_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 4;
  localparam int DEF_DEPTH      = 16;

  localparam int NUM_BANKS      = 2;
  localparam int NUM_RD_PORTS   = 2;

  localparam logic BANK_EMPTY   = 1'b0;
  localparam logic BANK_FULL    = 1'b1;

endpackage

// File: rtl/pingpong_buf_bank.sv
// One storage bank: a single write port and two independent registered read
// ports. Only the read registers are reset; the array itself keeps its data.
module pingpong_buf_bank
  import pingpong_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DEPTH      = DEF_DEPTH
) (
  input  logic                                      clk_i,
  input  logic                                      srst_i,
  input  logic                                      we_i,
  input  logic [ADDR_WIDTH-1:0]                     waddr_i,
  input  logic [DATA_WIDTH-1:0]                     wdata_i,
  input  logic [NUM_RD_PORTS-1:0]                   re_i,
  input  logic [NUM_RD_PORTS-1:0][ADDR_WIDTH-1:0]   raddr_i,
  output logic [NUM_RD_PORTS-1:0][DATA_WIDTH-1:0]   rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  for (genvar gi = 0; gi < NUM_RD_PORTS; gi++) begin : g_rd
    logic [DATA_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
      if (srst_i) begin
        rdata_q <= '0;
      end else if (re_i[gi]) begin
        rdata_q <= mem_q[raddr_i[gi]];
      end
    end

    assign rdata_o[gi] = rdata_q;
  end

endmodule

// File: rtl/pingpong_buf.sv
// Two-bank ping-pong buffer: the producer fills bank[iptr] and commits it,
// the consumer reads bank[tptr] over two read ports and releases it.
module pingpong_buf
  import pingpong_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DEPTH      = DEF_DEPTH
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic [ADDR_WIDTH-1:0] i_address0,
  input  logic                  i_ce0,
  input  logic                  i_we0,
  input  logic [DATA_WIDTH-1:0] i_d0,
  input  logic                  i_write,
  output logic                  i_full_n,
  input  logic [ADDR_WIDTH-1:0] t_address0,
  input  logic                  t_ce0,
  output logic [DATA_WIDTH-1:0] t_q0,
  input  logic [ADDR_WIDTH-1:0] t_address1,
  input  logic                  t_ce1,
  output logic [DATA_WIDTH-1:0] t_q1,
  input  logic                  t_read,
  output logic                  t_empty_n
);

  logic                    iptr_q, iptr_d;
  logic                    tptr_q, tptr_d;
  logic [NUM_BANKS-1:0]    status_q, status_d;
  // Bank that fed each read register last; keeps t_qN stable across a
  // tptr toggle that happens after the read was issued.
  logic [NUM_RD_PORTS-1:0] rsel_q, rsel_d;

  logic                    commit_ok;
  logic                    release_ok;
  logic                    wr_ok;
  logic [NUM_RD_PORTS-1:0] rd_en;
  logic [NUM_RD_PORTS-1:0][ADDR_WIDTH-1:0] rd_addr;
  logic [NUM_BANKS-1:0][NUM_RD_PORTS-1:0][DATA_WIDTH-1:0] bank_rdata;

  assign i_full_n   = (status_q[iptr_q] == BANK_EMPTY);
  assign t_empty_n  = (status_q[tptr_q] == BANK_FULL);
  assign commit_ok  = i_write & i_full_n;
  assign release_ok = t_read & t_empty_n;
  assign wr_ok      = i_ce0 & i_we0 & i_full_n;
  assign rd_en      = {t_ce1, t_ce0};
  assign rd_addr    = {t_address1, t_address0};

  // A commit needs an empty iptr bank and a release a full tptr bank, so the
  // two never target the same bank and can be applied together.
  always_comb begin
    iptr_d   = iptr_q;
    tptr_d   = tptr_q;
    status_d = status_q;
    rsel_d   = rsel_q;
    if (commit_ok) begin
      status_d[iptr_q] = BANK_FULL;
      iptr_d           = ~iptr_q;
    end
    if (release_ok) begin
      status_d[tptr_q] = BANK_EMPTY;
      tptr_d           = ~tptr_q;
    end
    for (int p = 0; p < NUM_RD_PORTS; p++) begin
      if (rd_en[p]) begin
        rsel_d[p] = tptr_q;
      end
    end
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      iptr_q   <= 1'b0;
      tptr_q   <= 1'b0;
      status_q <= {NUM_BANKS{BANK_EMPTY}};
      rsel_q   <= '0;
    end else begin
      iptr_q   <= iptr_d;
      tptr_q   <= tptr_d;
      status_q <= status_d;
      rsel_q   <= rsel_d;
    end
  end

  for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
    pingpong_buf_bank #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .DEPTH      (DEPTH)
    ) u_bank (
      .clk_i   (ap_clk),
      .srst_i  (ap_rst),
      .we_i    (wr_ok & (iptr_q == 1'(gi))),
      .waddr_i (i_address0),
      .wdata_i (i_d0),
      .re_i    (rd_en & {NUM_RD_PORTS{tptr_q == 1'(gi)}}),
      .raddr_i (rd_addr),
      .rdata_o (bank_rdata[gi])
    );
  end

  assign t_q0 = bank_rdata[rsel_q[0]][0];
  assign t_q1 = bank_rdata[rsel_q[1]][1];

endmodule

// File: tb/tb_pingpong_buf.sv
// Directed bench for pingpong_buf: read expectations go into per-port queues
// and a monitor checks them one cycle after each sampled read enable.
module tb_pingpong_buf;

  localparam int DW = 32;
  localparam int AW = 4;

  typedef struct {
    string       name;
    logic [DW-1:0] data;
  } exp_t;

  logic          ap_clk = 1'b0;
  logic          ap_rst;
  logic [AW-1:0] i_address0;
  logic          i_ce0, i_we0;
  logic [DW-1:0] i_d0;
  logic          i_write;
  logic          i_full_n;
  logic [AW-1:0] t_address0, t_address1;
  logic          t_ce0, t_ce1;
  logic [DW-1:0] t_q0, t_q1;
  logic          t_read;
  logic          t_empty_n;

  int total = 0;
  int bad   = 0;

  exp_t q0[$];
  exp_t q1[$];
  logic s0, s1;

  always #5 ap_clk = ~ap_clk;

  pingpong_buf #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(16)) dut (
    .ap_clk     (ap_clk),
    .ap_rst     (ap_rst),
    .i_address0 (i_address0),
    .i_ce0      (i_ce0),
    .i_we0      (i_we0),
    .i_d0       (i_d0),
    .i_write    (i_write),
    .i_full_n   (i_full_n),
    .t_address0 (t_address0),
    .t_ce0      (t_ce0),
    .t_q0       (t_q0),
    .t_address1 (t_address1),
    .t_ce1      (t_ce1),
    .t_q1       (t_q1),
    .t_read     (t_read),
    .t_empty_n  (t_empty_n)
  );

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end else begin
      $display("ok   %s: %0h", nm, act);
    end
  endtask

  // Monitor: a read enable seen on an edge has its data checked 1 ns later.
  always @(posedge ap_clk) begin
    exp_t e;
    s0 = t_ce0;
    s1 = t_ce1;
    #1;
    if (s0) begin
      if (q0.size() == 0) begin
        total++; bad++;
        $display("FAIL read0_unexpected: got %0h expected none", t_q0);
      end else begin
        e = q0.pop_front();
        chk(e.name, t_q0, e.data);
      end
    end
    if (s1) begin
      if (q1.size() == 0) begin
        total++; bad++;
        $display("FAIL read1_unexpected: got %0h expected none", t_q1);
      end else begin
        e = q1.pop_front();
        chk(e.name, t_q1, e.data);
      end
    end
  end

  task automatic step();
    @(negedge ap_clk);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    i_ce0 = 1'b1; i_we0 = 1'b1; i_address0 = a; i_d0 = d;
    step();
    i_ce0 = 1'b0; i_we0 = 1'b0;
  endtask

  task automatic fill(input logic [DW-1:0] mul, input logic [DW-1:0] base);
    for (int k = 0; k < 16; k++) begin
      wr(AW'(k), base + mul * DW'(k));
    end
  endtask

  task automatic commit();
    i_write = 1'b1; step(); i_write = 1'b0;
  endtask

  task automatic release_bank();
    t_read = 1'b1; step(); t_read = 1'b0;
  endtask

  task automatic rd(input logic en0, input logic [AW-1:0] a0, input logic [DW-1:0] e0,
                    input logic en1, input logic [AW-1:0] a1, input logic [DW-1:0] e1,
                    input string nm);
    t_ce0 = en0; t_address0 = a0;
    t_ce1 = en1; t_address1 = a1;
    if (en0) q0.push_back('{{nm, "_p0"}, e0});
    if (en1) q1.push_back('{{nm, "_p1"}, e1});
    step();
    t_ce0 = 1'b0; t_ce1 = 1'b0;
  endtask

  task automatic chk_state(input string nm, input logic fn, input logic en,
                           input logic ip, input logic tp);
    chk({nm, "_full_n"},  DW'(i_full_n),   DW'(fn));
    chk({nm, "_empty_n"}, DW'(t_empty_n),  DW'(en));
    chk({nm, "_iptr"},    DW'(dut.iptr_q), DW'(ip));
    chk({nm, "_tptr"},    DW'(dut.tptr_q), DW'(tp));
  endtask

  initial begin
    ap_rst = 1'b1;
    i_address0 = '0; i_ce0 = 1'b0; i_we0 = 1'b0; i_d0 = '0; i_write = 1'b0;
    t_address0 = '0; t_address1 = '0; t_ce0 = 1'b0; t_ce1 = 1'b0; t_read = 1'b0;
    repeat (2) step();
    ap_rst = 1'b0;

    // Reset state
    chk_state("reset", 1'b1, 1'b0, 1'b0, 1'b0);
    chk("reset_q0", t_q0, '0);
    chk("reset_q1", t_q1, '0);

    // Fill bank0 with k*3 and commit
    fill(3, 0);
    commit();
    chk_state("commit0", 1'b1, 1'b1, 1'b1, 1'b0);
    rd(1'b1, 4'd5, 32'd15, 1'b1, 4'd15, 32'd45, "b0_rd_5_15");
    step();
    chk("hold_q0", t_q0, 32'd15);
    chk("hold_q1", t_q1, 32'd45);

    // Fill bank1 with 100+k, both banks full, extra write and commit dropped
    fill(1, 100);
    commit();
    chk_state("both_full", 1'b0, 1'b1, 1'b0, 1'b0);
    wr(4'd0, 32'hDEAD);
    commit();
    chk_state("full_commit_ignored", 1'b0, 1'b1, 1'b0, 1'b0);
    rd(1'b1, 4'd0, 32'd0, 1'b1, 4'd0, 32'd0, "b0_addr0_same");
    rd(1'b1, 4'd7, 32'd21, 1'b0, 4'd0, 32'd0, "b0_addr7");

    // Release bank0, consumer moves to bank1
    release_bank();
    chk_state("release0", 1'b1, 1'b1, 1'b0, 1'b1);
    rd(1'b1, 4'd0, 32'd100, 1'b1, 4'd9, 32'd109, "b1_rd_0_9");

    // Simultaneous commit and release: bank0 full, bank1 being filled
    release_bank();
    chk_state("all_empty", 1'b1, 1'b0, 1'b0, 1'b0);
    fill(1, 200);
    commit();
    wr(4'd3, 32'h333);
    i_write = 1'b1; t_read = 1'b1;
    step();
    i_write = 1'b0; t_read = 1'b0;
    chk_state("simul", 1'b1, 1'b1, 1'b0, 1'b1);
    rd(1'b1, 4'd3, 32'h333, 1'b0, 4'd0, 32'd0, "simul_b1_addr3");

    // Spurious release while empty
    release_bank();
    chk_state("empty_again", 1'b1, 1'b0, 1'b0, 1'b0);
    release_bank();
    chk_state("spurious_read", 1'b1, 1'b0, 1'b0, 1'b0);

    // Mid-operation reset with a full bank; reset beats a same-edge commit
    wr(4'd2, 32'h55);
    commit();
    rd(1'b1, 4'd2, 32'h55, 1'b0, 4'd0, 32'd0, "pre_rst_addr2");
    chk_state("pre_rst", 1'b1, 1'b1, 1'b1, 1'b0);
    ap_rst = 1'b1; i_write = 1'b1;
    step();
    ap_rst = 1'b0; i_write = 1'b0;
    chk_state("mid_rst", 1'b1, 1'b0, 1'b0, 1'b0);
    chk("mid_rst_q0", t_q0, '0);

    // Bank contents survive reset
    commit();
    rd(1'b1, 4'd2, 32'h55, 1'b1, 4'd7, 32'd207, "post_rst_keep");

    repeat (2) step();
    total++;
    if (q0.size() != 0 || q1.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q0.size() + q1.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
